icache_nway_snoop: RTL and testbench

- Parametrised next-generation per-core instruction cache: tag/data array, N-way LRU replacement and bus-miss controller in one synchronous unit.
- Sits between one core's fetch port and the shared common bus, in the same position as the current per-core I-cache unit.
- Adds over the current unit: configurable sets/ways/widths, explicit miss FSM with grant-loss recovery and fill timeout-retry, bulk invalidate, and a saturating miss counter.
- Read-only: one word per line, no write path, no dirty state.

---
 rtl/icache_nway_snoop_if.sv | 35 +++
 rtl/icache_nway_snoop.sv | 160 ++++++++++++++++
 tb/tb_icache_nway_snoop.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_nway_snoop_if.sv
// rtl/icache_nway_snoop_if.sv - core fetch port and common-bus signals of the per-core I-cache
// Purpose: bundles the fetch handshake and the common-bus miss interface.
// Signals:
//   PrRd, Address                     core fetch request (core -> cache)
//   Data_out, Rd_valid, CPU_stall     fetch response (cache -> core)
//   Com_Bus_Req_proc, Address_Com,
//   Address_Com_oe                    bus request / address phase (cache -> bus)
//   Com_Bus_Gnt_proc, Data_Bus_Com,
//   Data_in_Bus                       grant and fill data (bus -> cache)
// Modports: master = cache side, slave = core/bus environment side.
interface icache_nway_snoop_if #(
  parameter int ADDR_W = 32
);
  logic              PrRd;
  logic [ADDR_W-1:0] Address;
  logic [ADDR_W-1:0] Data_out;
  logic              Rd_valid;
  logic              CPU_stall;
  logic              Com_Bus_Req_proc;
  logic              Com_Bus_Gnt_proc;
  logic [ADDR_W-1:0] Address_Com;
  logic              Address_Com_oe;
  logic [ADDR_W-1:0] Data_Bus_Com;
  logic              Data_in_Bus;

  modport master (
    input  PrRd, Address, Com_Bus_Gnt_proc, Data_Bus_Com, Data_in_Bus,
    output Data_out, Rd_valid, CPU_stall, Com_Bus_Req_proc, Address_Com, Address_Com_oe
  );

  modport slave (
    output PrRd, Address, Com_Bus_Gnt_proc, Data_Bus_Com, Data_in_Bus,
    input  Data_out, Rd_valid, CPU_stall, Com_Bus_Req_proc, Address_Com, Address_Com_oe
  );
endinterface

// File: rtl/icache_nway_snoop.sv
// rtl/icache_nway_snoop.sv - N-way read-only instruction cache with LRU and bus-miss controller
// Purpose: tag/data array with per-set LRU ages, one word per line, and a miss FSM
//   (IDLE -> REQ -> ADDR -> WAIT -> FILL) with grant-loss and timeout retry.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   bus          icache_nway_snoop_if.master (fetch port + common bus)
//   Inv_all      clear every valid bit (ages untouched)
//   Miss_count   saturating count of lookups that missed
module icache_nway_snoop #(
  parameter int ADDR_W  = 32,
  parameter int IDX_W   = 4,
  parameter int WAYS    = 4,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  icache_nway_snoop_if.master  bus,
  input  logic                 Inv_all,
  output logic [CNT_W-1:0]     Miss_count
);
  localparam int SETS   = 1 << IDX_W;
  localparam int TAG_W  = ADDR_W - IDX_W - 2;
  localparam int WAY_W  = $clog2(WAYS);
  localparam int TCNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ADDR, S_WAIT, S_FILL} state_t;
  state_t state, state_nxt;

  logic [SETS-1:0][WAYS-1:0] valid;
  logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
  logic [ADDR_W-1:0] data_mem [SETS][WAYS];
  logic [WAY_W-1:0]  age      [SETS][WAYS];

  logic [TCNT_W-1:0] tcnt;
  logic [ADDR_W-1:0] fill_data;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim;
  logic             victim_found;
  logic             lookup_hit;
  logic             lookup_miss;
  logic             acc_en;
  logic [WAY_W-1:0] acc_way;
  logic [WAY_W-1:0] old_age;
  logic             unused_offset;

  assign idx = bus.Address[IDX_W+1:2];
  assign tag = bus.Address[ADDR_W-1:IDX_W+2];
  assign unused_offset = ^bus.Address[1:0];

  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[idx][w] && tag_mem[idx][w] == tag) begin
        hit = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Lowest invalid way first; only when the set is full does the LRU way go.
  always_comb begin
    victim = '0;
    victim_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!valid[idx][w] && !victim_found) begin
        victim = WAY_W'(w);
        victim_found = 1'b1;
      end
    end
    if (!victim_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age[idx][w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
      end
    end
  end

  assign lookup_hit  = (state == S_IDLE) && bus.PrRd && hit;
  assign lookup_miss = (state == S_IDLE) && bus.PrRd && !hit;
  assign acc_en      = lookup_hit || (state == S_FILL);
  assign acc_way     = (state == S_FILL) ? victim : hit_way;
  assign old_age     = age[idx][acc_way];

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (lookup_miss) state_nxt = S_REQ;
      S_REQ:  if (bus.Com_Bus_Gnt_proc) state_nxt = S_ADDR;
      S_ADDR: state_nxt = bus.Com_Bus_Gnt_proc ? S_WAIT : S_REQ;
      S_WAIT: begin
        // Data wins over a same-cycle grant drop: the word is already on the bus.
        if (bus.Data_in_Bus) state_nxt = S_FILL;
        else if (!bus.Com_Bus_Gnt_proc || tcnt == TCNT_W'(TIMEOUT - 1)) state_nxt = S_REQ;
      end
      S_FILL: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.Com_Bus_Req_proc = (state == S_REQ) || (state == S_ADDR) || (state == S_WAIT);
    bus.Address_Com_oe   = (state == S_ADDR);
    bus.Address_Com      = (state == S_ADDR) ? {bus.Address[ADDR_W-1:2], 2'b00} : '0;
    bus.CPU_stall        = (state != S_IDLE) || lookup_miss;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid        <= '0;
      bus.Rd_valid <= 1'b0;
      bus.Data_out <= '0;
      Miss_count   <= '0;
      tcnt         <= '0;
      fill_data    <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age[s][w] <= WAY_W'(w);
    end else begin
      bus.Rd_valid <= 1'b0;
      if (lookup_hit) begin
        bus.Rd_valid <= 1'b1;
        bus.Data_out <= data_mem[idx][hit_way];
      end
      if (state == S_FILL) begin
        bus.Rd_valid <= 1'b1;
        bus.Data_out <= fill_data;
      end
      if (lookup_miss && Miss_count != '1) Miss_count <= Miss_count + 1'b1;
      if (state == S_ADDR)      tcnt <= '0;
      else if (state == S_WAIT) tcnt <= tcnt + 1'b1;
      if (state == S_WAIT && bus.Data_in_Bus) fill_data <= bus.Data_Bus_Com;
      // The fill write comes after the bulk clear so a concurrent fill survives.
      if (Inv_all) valid <= '0;
      if (state == S_FILL) valid[idx][victim] <= 1'b1;
      if (acc_en) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == acc_way)      age[idx][w] <= '0;
          else if (age[idx][w] < old_age) age[idx][w] <= age[idx][w] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_FILL) begin
      tag_mem[idx][victim]  <= tag;
      data_mem[idx][victim] <= fill_data;
    end
  end
endmodule

// File: tb/tb_icache_nway_snoop.sv
// tb/tb_icache_nway_snoop.sv - self-checking bench for icache_nway_snoop
module tb_icache_nway_snoop;
  localparam int AW = 32;
  localparam int IW = 4;
  localparam int NW = 4;
  localparam int TO = 64;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst;
  logic inv;
  logic [CW-1:0] miss_count;

  icache_nway_snoop_if #(.ADDR_W(AW)) bus ();

  icache_nway_snoop #(.ADDR_W(AW), .IDX_W(IW), .WAYS(NW), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .Inv_all(inv), .Miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: per set, resident lines ordered most- to least-recently used.
  logic [31:0] m_addr [1<<IW][NW];
  logic [31:0] m_data [1<<IW][NW];
  int          m_cnt  [1<<IW];
  logic [CW-1:0] exp_miss = '0;
  bit            exp_rv = 1'b0;
  logic [31:0]   exp_data = '0;

  function automatic int m_find(input logic [31:0] a);
    int s;
    s = int'(a[IW+1:2]);
    for (int i = 0; i < m_cnt[s]; i++)
      if (m_addr[s][i] == {a[31:2], 2'b00}) return i;
    return -1;
  endfunction

  function automatic logic [31:0] m_use(input logic [31:0] a, input logic [31:0] d);
    int s;
    int p;
    logic [31:0] v;
    s = int'(a[IW+1:2]);
    p = m_find(a);
    if (p >= 0) v = m_data[s][p];
    else begin
      v = d;
      if (m_cnt[s] < NW) m_cnt[s]++;
      p = m_cnt[s] - 1;
    end
    for (int i = p; i > 0; i--) begin
      m_addr[s][i] = m_addr[s][i-1];
      m_data[s][i] = m_data[s][i-1];
    end
    m_addr[s][0] = {a[31:2], 2'b00};
    m_data[s][0] = v;
    return v;
  endfunction

  function automatic void m_clear();
    for (int s = 0; s < (1 << IW); s++) m_cnt[s] = 0;
  endfunction

  always @(negedge clk) begin
    chk("miss_count", 32'(miss_count), 32'(exp_miss));
    chk("rd_valid", 32'(bus.Rd_valid), 32'(exp_rv));
    if (exp_rv) chk("data_out", bus.Data_out, exp_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input logic [31:0] a);
    chk("oe_addr", 32'(bus.Address_Com_oe), 32'd1);
    chk("address_com", bus.Address_Com, {a[31:2], 2'b00});
    tick();
    chk("oe_wait", 32'(bus.Address_Com_oe), 32'd0);
    chk("req_wait", 32'(bus.Com_Bus_Req_proc), 32'd1);
  endtask

  // Called in the first REQ cycle; returns in the cycle Rd_valid is due.
  task automatic serve(input logic [31:0] a, input logic [31:0] d, input int mode);
    int n;
    bit req_drop;
    chk("req_in_req", 32'(bus.Com_Bus_Req_proc), 32'd1);
    bus.Data_in_Bus = 1'b1;
    bus.Data_Bus_Com = 32'hBAD0_BAD0;
    bus.Com_Bus_Gnt_proc = 1'b1;
    tick();
    bus.Data_in_Bus = 1'b0;
    addr_phase(a);
    if (mode == 1) begin
      bus.Com_Bus_Gnt_proc = 1'b0;
      tick();
      chk("req_after_gnt_loss", 32'(bus.Com_Bus_Req_proc), 32'd1);
      chk("oe_after_gnt_loss", 32'(bus.Address_Com_oe), 32'd0);
      bus.Com_Bus_Gnt_proc = 1'b1;
      tick();
      addr_phase(a);
    end
    if (mode == 2) begin
      n = 0;
      req_drop = 1'b0;
      while (!bus.Address_Com_oe && n < TO + 10) begin
        if (!bus.Com_Bus_Req_proc) req_drop = 1'b1;
        tick();
        n++;
      end
      chk("timeout_retry_len", 32'(n >= TO && n <= TO + 2), 32'd1);
      chk("req_held_timeout", 32'(req_drop), 32'd0);
      addr_phase(a);
    end
    bus.Data_in_Bus = 1'b1;
    bus.Data_Bus_Com = d;
    tick();
    bus.Data_in_Bus = 1'b0;
    bus.Com_Bus_Gnt_proc = 1'b0;
    chk("stall_fill", 32'(bus.CPU_stall), 32'd1);
    chk("req_fill", 32'(bus.Com_Bus_Req_proc), 32'd0);
    tick();
  endtask

  task automatic read(input logic [31:0] a, input logic [31:0] d, input bit exp_hit,
                      input int mode, input bit with_inv);
    logic [31:0] md;
    chk("model_hit", 32'(m_find(a) >= 0), 32'(exp_hit));
    bus.PrRd = 1'b1;
    bus.Address = a;
    inv = with_inv;
    #1;
    chk("stall_lookup", 32'(bus.CPU_stall), 32'(!exp_hit));
    if (exp_hit) begin
      md = m_use(a, d);
      if (with_inv) m_clear();
      tick();
      bus.PrRd = 1'b0;
      inv = 1'b0;
    end else begin
      tick();
      inv = 1'b0;
      if (exp_miss != '1) exp_miss = exp_miss + 1'b1;
      serve(a, d, mode);
      md = m_use(a, d);
      bus.PrRd = 1'b0;
    end
    exp_rv = 1'b1;
    exp_data = md;
    #1;
    chk("stall_done", 32'(bus.CPU_stall), 32'd0);
    tick();
    exp_rv = 1'b0;
  endtask

  logic [31:0] ta [10];
  bit          th [10];

  initial begin
    rst = 1'b1;
    inv = 1'b0;
    bus.PrRd = 1'b0;
    bus.Address = '0;
    bus.Com_Bus_Gnt_proc = 1'b0;
    bus.Data_Bus_Com = '0;
    bus.Data_in_Bus = 1'b0;
    m_clear();
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_data_out", bus.Data_out, 32'd0);
    chk("rst_stall", 32'(bus.CPU_stall), 32'd0);
    chk("rst_req", 32'(bus.Com_Bus_Req_proc), 32'd0);
    chk("rst_addr_com", bus.Address_Com, 32'd0);
    chk("rst_oe", 32'(bus.Address_Com_oe), 32'd0);

    read(32'h0000_0040, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
    chk("miss_count_first", 32'(miss_count), 32'd1);
    read(32'h0000_0040, 32'h0, 1'b1, 0, 1'b0);
    chk("miss_count_hit", 32'(miss_count), 32'd1);

    ta = '{32'h000, 32'h040, 32'h080, 32'h0C0, 32'h100, 32'h040, 32'h000, 32'h040, 32'h080, 32'h100};
    th = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 10; i++) read(ta[i], 32'hC0DE_0000 + 32'(i), th[i], 0, 1'b0);
    chk("miss_count_lru", 32'(miss_count), 32'd7);

    bus.PrRd = 1'b1;
    bus.Address = 32'h100;
    #1;
    chk("stall_b2b_a", 32'(bus.CPU_stall), 32'd0);
    tick();
    bus.Address = 32'h080;
    exp_rv = 1'b1;
    exp_data = m_use(32'h100, 32'h0);
    #1;
    chk("stall_b2b_b", 32'(bus.CPU_stall), 32'd0);
    tick();
    bus.PrRd = 1'b0;
    exp_data = m_use(32'h080, 32'h0);
    tick();
    exp_rv = 1'b0;

    read(32'h0000_0200, 32'h7777_0001, 1'b0, 2, 1'b0);
    chk("miss_count_timeout", 32'(miss_count), 32'd8);
    read(32'h0000_0204, 32'h7777_0002, 1'b0, 1, 1'b0);
    chk("miss_count_gnt_loss", 32'(miss_count), 32'd9);

    read(32'h0000_0040, 32'h0, 1'b1, 0, 1'b1);
    read(32'h0000_0040, 32'h4040_4040, 1'b0, 0, 1'b0);
    inv = 1'b1;
    tick();
    inv = 1'b0;
    m_clear();
    read(32'h0000_0040, 32'h4141_4141, 1'b0, 0, 1'b0);
    chk("miss_count_inv", 32'(miss_count), 32'd11);

    bus.PrRd = 1'b1;
    bus.Address = 32'h1234_5678;
    tick();
    exp_miss = exp_miss + 1'b1;
    bus.Com_Bus_Gnt_proc = 1'b1;
    tick();
    tick();
    chk("req_before_rst", 32'(bus.Com_Bus_Req_proc), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.PrRd = 1'b0;
    bus.Com_Bus_Gnt_proc = 1'b0;
    exp_miss = '0;
    m_clear();
    #1;
    chk("rst_wait_req", 32'(bus.Com_Bus_Req_proc), 32'd0);
    chk("rst_wait_oe", 32'(bus.Address_Com_oe), 32'd0);
    chk("rst_wait_stall", 32'(bus.CPU_stall), 32'd0);
    tick();
    read(32'h0000_0040, 32'h5151_5151, 1'b0, 0, 1'b0);
    chk("miss_count_after_rst", 32'(miss_count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
